// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types and constants for the pipeline hazard controller.
//   sb_entry_t : one scoreboard slot {valid, rd, regwr, load}
//   REG_X0     : hard-wired zero register, never a forwarding source
//   FWD_RF     : forward-select value meaning "use register file"
//   FWD_STAGE  : forward-select value for a producer sitting in stage k
package hazard_ctrl_pkg;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwr;
      logic       load;
   } sb_entry_t;

   localparam logic [4:0] REG_X0 = 5'd0;
   localparam int         FWD_RF = 0;

   function automatic int FWD_STAGE(input int k);
      return k - 1;
   endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: combinational youngest-producer search for one source register.
//   ent_i     : scoreboard, index k-1 holds stage k
//   src_i     : source register to look up
//   use_i     : the consumer actually reads src_i
//   hit_o     : a live, writing, non-x0 producer of src_i exists in stages FIRST..DEPTH
//   stage_o   : stage number of the youngest such producer
//   is_load_o : that producer is a load
module hazard_match
   import hazard_ctrl_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int FIRST = 1,
   parameter int STW   = $clog2(DEPTH + 1)
)(
   input  sb_entry_t [DEPTH-1:0] ent_i,
   input  logic [4:0]            src_i,
   input  logic                  use_i,
   output logic                  hit_o,
   output logic [STW-1:0]        stage_o,
   output logic                  is_load_o
);

   // Walk from oldest to youngest so the youngest match is written last and wins.
   always_comb begin
      hit_o     = 1'b0;
      stage_o   = '0;
      is_load_o = 1'b0;
      for (int k = DEPTH; k >= FIRST; k--) begin
         if (use_i && ent_i[k-1].valid && ent_i[k-1].regwr &&
             ent_i[k-1].rd == src_i && ent_i[k-1].rd != REG_X0) begin
            hit_o     = 1'b1;
            stage_o   = STW'(k);
            is_load_o = ent_i[k-1].load;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: parametrised hazard controller for the RV32I pipeline.
// Tracks destination registers of DEPTH stages after ID and drives:
//   fwd_rs1_sel/fwd_rs2_sel : EX operand source, 0 = regfile, k = stage k+1
//   stall_if                : hold PC and IF/ID
//   bubble_ex               : inject an invalid entry into ID/EX (load-use)
//   flush_ifid              : clear IF/ID on a taken redirect
//   stage_valid             : bit k-1 = stage k live
//   stall_count/flush_count : saturating performance counters
// Inputs: clock, clr_n (async active-low), ID instruction fields, ex_busy,
// redirect_valid. Priority: redirect > ex_busy > load-use > normal.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int DEPTH        = 3,
   parameter int LOAD_READY   = 3,
   parameter int BRANCH_STAGE = 2,
   parameter int CNT_W        = 32,
   parameter int SELW         = $clog2(DEPTH)
)(
   input  logic             clock,
   input  logic             clr_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_regwr,
   input  logic             id_load,
   input  logic             ex_busy,
   input  logic             redirect_valid,
   output logic [SELW-1:0]  fwd_rs1_sel,
   output logic [SELW-1:0]  fwd_rs2_sel,
   output logic             stall_if,
   output logic             bubble_ex,
   output logic             flush_ifid,
   output logic [DEPTH-1:0] stage_valid,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int STW = $clog2(DEPTH + 1);

   sb_entry_t [DEPTH-1:0] ent_q, ent_d;
   // Source info is only needed for the EX entry (stage 1).
   logic [4:0]       ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
   logic             ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   logic           ex_hit1, ex_hit2, id_hit1, id_hit2;
   logic           ex_ld1, ex_ld2, id_ld1, id_ld2;
   logic [STW-1:0] ex_st1, ex_st2, id_st1, id_st2;
   logic           lu_rs1, lu_rs2, load_use;
   logic           unused_ex_ld;

   // EX forwarding: producers are stages 2..DEPTH.
   hazard_match #(.DEPTH(DEPTH), .FIRST(2), .STW(STW)) u_ex_rs1 (
      .ent_i(ent_q), .src_i(ex_rs1_q), .use_i(ex_use1_q & ent_q[0].valid),
      .hit_o(ex_hit1), .stage_o(ex_st1), .is_load_o(ex_ld1));
   hazard_match #(.DEPTH(DEPTH), .FIRST(2), .STW(STW)) u_ex_rs2 (
      .ent_i(ent_q), .src_i(ex_rs2_q), .use_i(ex_use2_q & ent_q[0].valid),
      .hit_o(ex_hit2), .stage_o(ex_st2), .is_load_o(ex_ld2));

   // Load-use lookup: producers are stages 1..DEPTH; a younger non-load shadows an older load.
   hazard_match #(.DEPTH(DEPTH), .FIRST(1), .STW(STW)) u_id_rs1 (
      .ent_i(ent_q), .src_i(id_rs1), .use_i(id_use_rs1),
      .hit_o(id_hit1), .stage_o(id_st1), .is_load_o(id_ld1));
   hazard_match #(.DEPTH(DEPTH), .FIRST(1), .STW(STW)) u_id_rs2 (
      .ent_i(ent_q), .src_i(id_rs2), .use_i(id_use_rs2),
      .hit_o(id_hit2), .stage_o(id_st2), .is_load_o(id_ld2));

   assign unused_ex_ld = ex_ld1 ^ ex_ld2;

   // Load at stage s forwards its data from stage s+1; too early if that is before LOAD_READY.
   assign lu_rs1   = id_hit1 && id_ld1 && (int'(id_st1) + 1 < LOAD_READY);
   assign lu_rs2   = id_hit2 && id_ld2 && (int'(id_st2) + 1 < LOAD_READY);
   assign load_use = id_valid && (lu_rs1 || lu_rs2);

   // Outputs are forced to zero while reset is asserted, even with live inputs.
   assign flush_ifid = clr_n && redirect_valid;
   assign stall_if   = clr_n && !redirect_valid && (ex_busy || load_use);
   assign bubble_ex  = clr_n && !redirect_valid && !ex_busy && load_use;

   assign fwd_rs1_sel = (clr_n && ex_hit1) ? SELW'(FWD_STAGE(int'(ex_st1))) : SELW'(FWD_RF);
   assign fwd_rs2_sel = (clr_n && ex_hit2) ? SELW'(FWD_STAGE(int'(ex_st2))) : SELW'(FWD_RF);

   assign stall_count = clr_n ? stall_cnt_q : '0;
   assign flush_count = clr_n ? flush_cnt_q : '0;

   for (genvar g = 0; g < DEPTH; g++) begin : g_sv
      assign stage_valid[g] = clr_n && ent_q[g].valid;
   end

   always_comb begin
      ent_d       = ent_q;
      ex_rs1_d    = ex_rs1_q;
      ex_rs2_d    = ex_rs2_q;
      ex_use1_d   = ex_use1_q;
      ex_use2_d   = ex_use2_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (redirect_valid) begin
         // Kill ID and everything younger than the branch; the branch itself moves on.
         ent_d[0] = '0;
         for (int k = 1; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
            if (k < BRANCH_STAGE) ent_d[k].valid = 1'b0;
         end
         if (~&flush_cnt_q) flush_cnt_d = flush_cnt_q + 1'b1;
      end else if (ex_busy) begin
         // EX holds its instruction; a bubble drains into stage 2.
         ent_d[1] = '0;
         for (int k = 2; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
         if (~&stall_cnt_q) stall_cnt_d = stall_cnt_q + 1'b1;
      end else if (load_use) begin
         ent_d[0] = '0;
         for (int k = 1; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
         if (~&stall_cnt_q) stall_cnt_d = stall_cnt_q + 1'b1;
      end else begin
         ent_d[0].valid = id_valid;
         ent_d[0].rd    = id_rd;
         ent_d[0].regwr = id_regwr;
         ent_d[0].load  = id_load;
         ex_rs1_d       = id_rs1;
         ex_rs2_d       = id_rs2;
         ex_use1_d      = id_use_rs1;
         ex_use2_d      = id_use_rs2;
         for (int k = 1; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
      end
   end

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         ent_q       <= '0;
         ex_rs1_q    <= '0;
         ex_rs2_q    <= '0;
         ex_use1_q   <= 1'b0;
         ex_use2_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ent_q       <= ent_d;
         ex_rs1_q    <= ex_rs1_d;
         ex_rs2_q    <= ex_rs2_d;
         ex_use1_q   <= ex_use1_d;
         ex_use2_q   <= ex_use2_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the RV32I pipeline. It replaces the fixed two-stage forwarding detector and the load-use detector.
- Keeps a scoreboard of in-flight destination registers for DEPTH stages downstream of ID (stage 1 = EX, 2 = MEM, 3 = WB, ...).
- Drives operand forward selects for the EX instruction, load-use stall/bubble, multi-cycle EX freeze, and branch-redirect flush.
- Keeps saturating stall and flush performance counters.

Parameters:
- DEPTH, 3: stages tracked after ID; must be >= 2.
- LOAD_READY, 3: first stage whose forwarded value carries load data; 2 <= LOAD_READY <= DEPTH.
- BRANCH_STAGE, 2: stage that asserts redirect_valid; 1 <= BRANCH_STAGE <= DEPTH.
- CNT_W, 32: width of the performance counters.
- SELW, $clog2(DEPTH): forward-select width (derived).

Ports:
- clock, in, 1: rising-edge clock.
- clr_n, in, 1: asynchronous active-low reset.
- id_valid, in, 1: ID holds a real instruction.
- id_rs1, in, 5: ID source register 1.
- id_rs2, in, 5: ID source register 2.
- id_use_rs1, in, 1: ID instruction reads rs1.
- id_use_rs2, in, 1: ID instruction reads rs2.
- id_rd, in, 5: ID destination register.
- id_regwr, in, 1: ID instruction writes rd.
- id_load, in, 1: ID instruction is a load.
- ex_busy, in, 1: multi-cycle EX operation not yet complete.
- redirect_valid, in, 1: branch/jump in BRANCH_STAGE is taken.
- fwd_rs1_sel, out, SELW: 0 = register file; k = value from stage k+1.
- fwd_rs2_sel, out, SELW: same encoding as fwd_rs1_sel, for rs2.
- stall_if, out, 1: hold PC and the IF/ID register.
- bubble_ex, out, 1: load an invalid entry into ID/EX.
- flush_ifid, out, 1: clear the IF/ID register.
- stage_valid, out, DEPTH: bit k-1 = stage k holds a live instruction.
- stall_count, out, CNT_W: stalled cycles, saturating.
- flush_count, out, CNT_W: redirects, saturating.

Behaviour:
- Reset is asynchronous and active-low: clr_n=0 invalidates all scoreboard entries and clears both counters at once, including mid-stall or mid-busy. Every output reads 0 while clr_n=0.
- Scoreboard entry k (1..DEPTH) holds {valid, rd, regwr, load}. Entry 1 also holds rs1, rs2, use_rs1, use_rs2.
- Forwarding (combinational from entries, zero latency):
  - For operand X of entry 1, find the smallest k in 2..DEPTH with valid & regwr & rd==X & rd!=0 & use_X.
  - sel = k-1 if found, else 0. The youngest producer wins. x0 is never forwarded.
  - If entry 1 is invalid, sel = 0.
- Load-use condition, evaluated when id_valid: for each used ID operand, find the youngest matching producer in entries 1..DEPTH (same match rule).
  - Stall if that producer is a load at stage s with s+1 < LOAD_READY.
  - A younger non-load producer of the same rd shadows an older load, so no stall.
- Priority each cycle: redirect_valid > ex_busy > load-use > normal.
- Redirect:
  - flush_ifid=1; stall_if=0; bubble_ex=0.
  - At the edge, the ID instruction and entries 1..BRANCH_STAGE-1 are killed. Next-cycle entries 1..BRANCH_STAGE are invalid; the branch moves to BRANCH_STAGE+1 (dropped if > DEPTH).
  - flush_count += 1.
- ex_busy:
  - stall_if=1; ID and entry 1 hold.
  - Entry 2 receives a bubble; entries >= 3 shift.
  - EX must latch its operands when the multi-cycle operation starts.
  - stall_count += 1.
- Load-use:
  - stall_if=1, bubble_ex=1.
  - Entry 1 becomes invalid; entries 2..DEPTH shift; ID holds.
  - stall_count += 1.
- Normal: entry 1 <= ID fields (valid=id_valid); entry k <= entry k-1; entry DEPTH's old contents drop.
- Counters saturate at all-ones with no wrap.
- Every output is a function of registered state plus current inputs only; there are no combinational loops from outputs back to inputs.

Decomposition:
- Shared package holds:
  - the sb_entry_t struct {valid, rd, regwr, load};
  - the REG_X0 constant;
  - the forward-select encoding constants FWD_RF=0 and FWD_STAGE(k)=k-1.
- One sub-module, hazard_match: a combinational youngest-producer search returning {hit, stage, is_load} for one source register. It is instantiated four times: EX rs1/rs2 and ID rs1/rs2.

Test Plan (DEPTH=3, LOAD_READY=3, BRANCH_STAGE=2):
1. Reset: drive clr_n=0 for 2 cycles during a load-use stall -> all outputs 0 immediately, both counters 0; after release, stage_valid=000 until the first issue.
2. ALU forward: add x5 then sub x6,x5,x1 issued back-to-back -> sub in EX gives fwd_rs1_sel=1. Insert one nop between them -> fwd_rs1_sel=2. With rd=x0 -> sel=0.
3. Load-use: lw x6 then add x7,x6,x6 -> one cycle with stall_if=1, bubble_ex=1, stall_count=1; next cycle add in EX has fwd_rs1_sel=fwd_rs2_sel=2.
4. Shadowing: lw x7, add x7,x1,x1, or x8,x7,x0 -> no stall; or in EX gives fwd_rs1_sel=1.
5. Redirect during load-use: assert redirect_valid in the same cycle as the load-use condition -> flush_ifid=1, stall_if=0, bubble_ex=0; next stage_valid[1:0]=00; flush_count=1, stall_count unchanged.
6. ex_busy held 3 cycles with a consumer in ID -> stall_if=1 for 3 cycles, entry 1 unchanged, stall_count=3; entry 2 is invalid after the first busy edge.
